// File: rtl/lsu_ctrl.sv
// Load/store unit controller: validates a byte-addressed request, drives a
// word-organised RAM with lane-replicated store data, and returns extended load data.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [2:0]        mem_mode,
  output logic [1:0]        mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP,
    S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                req_illegal;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Alignment and encoding check on the incoming request; only the low address bits matter.
  always_comb begin
    req_illegal = 1'b1;
    case (req_funct3)
      3'b000:  req_illegal = 1'b0;
      3'b001:  req_illegal = req_addr[0];
      3'b010:  req_illegal = (req_addr[1:0] != 2'b00);
      3'b100:  req_illegal = req_we;
      3'b101:  req_illegal = req_we | req_addr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext  = mem_rdata;
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (req_illegal)  state_d = S_ERR;
          else if (req_we)  state_d = S_WRITE;
          else              state_d = S_READ;
        end
      end
      S_WRITE:   state_d = S_RESP;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        rdata_d = ld_ext;
        state_d = S_RESP;
      end
      S_RESP:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Memory-side fields come straight from the latched request for the whole transaction.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_mode  = 3'b000;
    mem_cs    = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = (state_q == S_WRITE);
    rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    rsp_err   = (state_q == S_ERR);
    rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0000_0000;
    if (state_q != S_IDLE) begin
      mem_cs   = addr_q[1:0];
      mem_addr = addr_q[ADDR_W-1:2];
      case (funct3_q[1:0])
        2'b00: begin
          mem_mode  = 3'b001;
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_mode  = 3'b010;
          mem_wdata = {2{wdata_q[15:0]}};
        end
        2'b10: begin
          mem_mode  = 3'b100;
          mem_wdata = wdata_q;
        end
        default: begin
          mem_mode  = 3'b000;
          mem_wdata = '0;
        end
      endcase
    end
  end

endmodule
